// File: rtl/axis_sc_fifo.sv
// -----------------------------------------------------------------------------
// axis_sc_fifo
//
// Single-clock AXI-Stream FIFO. Buffers up to DEEP words between a producer
// and a consumer on the same clock. It exports the fill level and
// almost-full/almost-empty threshold flags, and supports a synchronous flush.
//
// Parameters
//   WIDTH        data width in bits
//   DEEP         capacity in words (power of two, >= 2)
//   AFULL_LEVEL  almost_full asserts when level >= AFULL_LEVEL (1..DEEP)
//   AEMPTY_LEVEL almost_empty asserts when level <= AEMPTY_LEVEL (0..DEEP-1)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset (pointers and flags only)
//   flush        synchronous discard of all stored words
//   s_rx_tdata   input data
//   s_rx_tvalid  input valid
//   s_rx_tready  input ready (registered)
//   m_tx_tdata   output data (combinational read of the head entry)
//   m_tx_tvalid  output valid (level != 0)
//   m_tx_tready  output ready
//   level        number of stored words (registered)
//   almost_full  registered threshold flag
//   almost_empty registered threshold flag
// -----------------------------------------------------------------------------
module axis_sc_fifo #(
  parameter int WIDTH        = 12,
  parameter int DEEP         = 32,
  parameter int AFULL_LEVEL  = 28,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         s_rx_tdata,
  input  logic                     s_rx_tvalid,
  output logic                     s_rx_tready,
  output logic [WIDTH-1:0]         m_tx_tdata,
  output logic                     m_tx_tvalid,
  input  logic                     m_tx_tready,
  output logic [$clog2(DEEP):0]    level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEEP);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] DEEP_L   = PW'(DEEP);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

  // Storage has no reset; only pointers and flags are cleared.
  logic [WIDTH-1:0] mem [DEEP];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // and both wrap modulo 2*DEEP.
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] level_next;

  logic wr;
  logic rd;

  // A flush cycle swallows any handshake that would otherwise complete.
  assign wr = s_rx_tvalid && s_rx_tready && !flush;
  assign rd = m_tx_tvalid && m_tx_tready && !flush;

  assign m_tx_tvalid = (level != '0);
  assign m_tx_tdata  = mem[rp[AW-1:0]];

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({wr, rd})
        2'b10:   level_next = level + ONE;
        2'b01:   level_next = level - ONE;
        default: level_next = level;
      endcase
    end
  end

  // Control state: pointers, level, ready and threshold flags. Ready and
  // flags are registered from level_next so they agree with level in the
  // same cycle; a read at full therefore only reopens ready next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      level        <= '0;
      s_rx_tready  <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr) wp <= wp + ONE;
        if (rd) rp <= rp + ONE;
      end
      level        <= level_next;
      s_rx_tready  <= (level_next != DEEP_L) && !flush;
      almost_full  <= (level_next >= AFULL_L);
      almost_empty <= (level_next <= AEMPTY_L);
    end
  end

  // Data storage: written only on an accepted word.
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= s_rx_tdata;
  end

endmodule
